ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage of the pico core. Owns the program counter (PC) and drives the
//  combinational instruction ROM address. It captures the returned instruction word with
//  its PC into a 2-entry output queue, which feeds decode over a valid/ready handshake.
//  Supports branch/jump redirect with queue flush, and a halt input.
// PARAMETERS
//  A        8             PC/ROM address width in words (pico::A)
//  W_INST   32            instruction width in bits (pico::W_INST)
//  RESET_PC '0            PC value loaded on reset, A bits
// PORTS
//  clk            in   1       core clock; all state on rising edge
//  rst            in   1       synchronous reset, active-high
//  rom_addr_o     out  A       word address to instruction ROM (= pc)
//  rom_data_i     in   W_INST  ROM read data, valid same cycle as rom_addr_o
//  redirect_i     in   1       branch/jump taken: flush queue, load redirect_pc_i
//  redirect_pc_i  in   A       new PC for redirect
//  halt_i         in   1       stop fetching; queue continues to drain
//  inst_valid_o   out  1       head of queue holds an instruction
//  inst_ready_i   in   1       decode accepts head this cycle
//  inst_o         out  W_INST  head instruction (0 when queue empty)
//  inst_pc_o      out  A       PC of head instruction (0 when queue empty)
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  - On rst: pc<=RESET_PC, count<=0, both entries<=0.
//  - Outputs after reset: inst_valid_o=0, inst_o=0, inst_pc_o=0, rom_addr_o=RESET_PC.
//  State:
//  - pc (A bits).
//  - 2-entry FIFO of {pc, inst} with count 0..2 and head pointer.
//  - No explicit FSM; behaviour is fully defined by count, redirect_i and halt_i.
//  Output decode:
//  - rom_addr_o = pc, combinational from the pc register.
//  - inst_valid_o = (count!=0), from registered state only; no combinational path from inputs.
//  Per-cycle terms:
//  - deq   = inst_valid_o & inst_ready_i
//  - fetch = !halt_i & !redirect_i & (count<2 | deq)
//  Normal fetch:
//  - fetch: push {pc, rom_data_i}; pc <= pc+1 mod 2^A (0xFF wraps to 0x00 for A=8; no flag).
//  - Latency: PC presented in cycle N -> inst_valid_o with that PC in cycle N+1.
//  - Throughput: 1 instruction/cycle when decode is always ready.
//  Queue full / empty:
//  - Full (count==2) with no deq: no push, pc holds, rom_addr_o stable.
//  - Full with deq in the same cycle: pop head and push new entry; count stays 2.
//  - Empty with deq: impossible, because inst_valid_o=0.
//  Redirect (highest priority after rst):
//  - count<=0 and pc<=redirect_pc_i; no push that cycle.
//  - A head handshaken in the same cycle counts as consumed; it is not replayed.
//  - The first instruction from the new PC is valid 2 cycles after redirect_i
//    (pc loads at edge, fetched next cycle, valid the following cycle).
//  Halt:
//  - pc holds and no push; the queue drains normally via deq.
//  - redirect_i during halt still loads pc and flushes the queue.
//  Reset mid-operation: all state returns to reset values at that edge.
//  - Queued instructions are discarded.
// TESTING
//  1 rst 1 cycle, ROM[i]=0x1000_0000+i, ready=1 -> cycle after rst rom_addr_o=0, valid=0;
//    next cycle valid=1, inst=0x1000_0000, pc=0; then pc 1,2,3 on consecutive cycles.
//  2 ready=0 from reset -> count fills to 2 (pc 0,1 queued), rom_addr_o holds 2;
//    ready=1 -> outputs pc 0,1,2,3 back-to-back, no gap, no duplicate.
//  3 queue full, redirect_i=1, redirect_pc_i=0x40 -> next cycle valid=0, rom_addr_o=0x40;
//    following cycle valid=1, inst_pc_o=0x40, inst=ROM[0x40].
//  4 redirect_i and deq in same cycle, head pc=5 -> pc 5 consumed once, then stream resumes at redirect target.
//  5 RESET_PC=0xFE, A=8, ready=1 -> inst_pc_o sequence 0xFE,0xFF,0x00,0x01.
//  6 halt_i=1 with 2 queued -> both drain, valid=0, rom_addr_o frozen;
//    rst asserted mid-stream -> valid=0 and rom_addr_o=RESET_PC next cycle.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction ROM port, redirect/halt control, and the decode handshake.
// master is the fetch unit; slave is the ROM/decode/branch environment around it.
interface ifetch_unit_if #(
   parameter int A      = 8,
   parameter int W_INST = 32
);
   logic [A-1:0]      rom_addr_o;
   logic [W_INST-1:0] rom_data_i;
   logic              redirect_i;
   logic [A-1:0]      redirect_pc_i;
   logic              halt_i;
   logic              inst_valid_o;
   logic              inst_ready_i;
   logic [W_INST-1:0] inst_o;
   logic [A-1:0]      inst_pc_o;

   modport master (
      output rom_addr_o, inst_valid_o, inst_o, inst_pc_o,
      input  rom_data_i, redirect_i, redirect_pc_i, halt_i, inst_ready_i
   );

   modport slave (
      input  rom_addr_o, inst_valid_o, inst_o, inst_pc_o,
      output rom_data_i, redirect_i, redirect_pc_i, halt_i, inst_ready_i
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, reads the ROM combinationally, and buffers
// {pc, inst} pairs in a 2-entry queue toward decode. Redirect flushes the queue.
module ifetch_unit #(
   parameter int           A        = 8,
   parameter int           W_INST   = 32,
   parameter logic [A-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   ifetch_unit_if.master bus
);

   logic [A-1:0]      pc_q,   pc_d;
   logic [1:0]        count_q, count_d;
   logic              head_q, head_d;
   logic [A-1:0]      ent_pc_q   [2];
   logic [A-1:0]      ent_pc_d   [2];
   logic [W_INST-1:0] ent_inst_q [2];
   logic [W_INST-1:0] ent_inst_d [2];

   logic deq;
   logic fetch;
   logic tail;

   // Outputs depend only on registered state, so decode sees no input-to-output path.
   assign bus.rom_addr_o   = pc_q;
   assign bus.inst_valid_o = (count_q != 2'd0);
   assign bus.inst_o       = bus.inst_valid_o ? ent_inst_q[head_q] : '0;
   assign bus.inst_pc_o    = bus.inst_valid_o ? ent_pc_q[head_q]   : '0;

   assign deq   = bus.inst_valid_o & bus.inst_ready_i;
   assign fetch = !bus.halt_i && !bus.redirect_i && ((count_q != 2'd2) || deq);
   // Tail is head+count mod 2; when full it aliases the head slot being popped.
   assign tail  = head_q ^ count_q[0];

   always_comb begin
      // NOTE: every _d gets a default first so no path through this block infers a latch.
      pc_d       = pc_q;
      count_d    = count_q;
      head_d     = head_q;
      ent_pc_d   = ent_pc_q;
      ent_inst_d = ent_inst_q;

      if (bus.redirect_i) begin
         pc_d    = bus.redirect_pc_i;
         count_d = 2'd0;
         head_d  = 1'b0;
      end else begin
         if (deq) begin
            head_d = ~head_q;
         end
         if (fetch) begin
            ent_pc_d[tail]   = pc_q;
            ent_inst_d[tail] = bus.rom_data_i;
            pc_d             = pc_q + A'(1);
         end
         count_d = count_q - {1'b0, deq} + {1'b0, fetch};
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         pc_q    <= RESET_PC;
         count_q <= 2'd0;
         head_q  <= 1'b0;
         // NOTE: the queue storage is cleared on reset too, so no stale entry survives it.
         for (int i = 0; i < 2; i++) begin
            ent_pc_q[i]   <= '0;
            ent_inst_q[i] <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         count_q    <= count_d;
         head_q     <= head_d;
         ent_pc_q   <= ent_pc_d;
         ent_inst_q <= ent_inst_d;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: ROM[i] = 0x1000_0000 + i, one DUT at RESET_PC=0
// and a second at RESET_PC=0xFE to exercise PC wrap.
module tb_ifetch_unit;
   localparam int A = 8;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ifetch_unit_if #(.A(A), .W_INST(W)) bus  ();
   ifetch_unit_if #(.A(A), .W_INST(W)) bus2 ();

   assign bus.rom_data_i  = 32'h1000_0000 + 32'(bus.rom_addr_o);
   assign bus2.rom_data_i = 32'h1000_0000 + 32'(bus2.rom_addr_o);

   ifetch_unit #(.A(A), .W_INST(W), .RESET_PC(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   ifetch_unit #(.A(A), .W_INST(W), .RESET_PC(8'hFE)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.master)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_head(input string tag, input logic [A-1:0] pc);
      check({tag, ".valid"}, 32'(bus.inst_valid_o), 32'd1);
      check({tag, ".pc"},    32'(bus.inst_pc_o),    32'(pc));
      check({tag, ".inst"},  bus.inst_o,            32'h1000_0000 + 32'(pc));
   endtask

   task automatic expect_empty(input string tag, input logic [A-1:0] addr);
      check({tag, ".valid"}, 32'(bus.inst_valid_o), 32'd0);
      check({tag, ".inst"},  bus.inst_o,            32'd0);
      check({tag, ".pc"},    32'(bus.inst_pc_o),    32'd0);
      check({tag, ".addr"},  32'(bus.rom_addr_o),   32'(addr));
   endtask

   task automatic do_reset(input logic ready);
      rst = 1'b1;
      bus.inst_ready_i = ready;
      step();
      rst = 1'b0;
   endtask

   initial begin
      bus.redirect_i     = 1'b0;
      bus.redirect_pc_i  = '0;
      bus.halt_i         = 1'b0;
      bus.inst_ready_i   = 1'b1;
      bus2.redirect_i    = 1'b0;
      bus2.redirect_pc_i = '0;
      bus2.halt_i        = 1'b0;
      bus2.inst_ready_i  = 1'b1;

      // 1 + 5: streaming from reset with decode always ready; second DUT wraps.
      do_reset(1'b1);
      expect_empty("t1.rst", 8'h00);
      check("t5.rst.addr", 32'(bus2.rom_addr_o), 32'h0000_00FE);
      check("t5.rst.valid", 32'(bus2.inst_valid_o), 32'd0);
      begin
         logic [A-1:0] exp2 [4];
         exp2[0] = 8'hFE; exp2[1] = 8'hFF; exp2[2] = 8'h00; exp2[3] = 8'h01;
         for (int i = 0; i < 4; i++) begin
            step();
            expect_head($sformatf("t1.s%0d", i), A'(i));
            check($sformatf("t5.s%0d.pc", i), 32'(bus2.inst_pc_o), 32'(exp2[i]));
            check($sformatf("t5.s%0d.inst", i), bus2.inst_o, 32'h1000_0000 + 32'(exp2[i]));
         end
      end

      // 2: stall fills the queue, then back-to-back drain with no gap or duplicate.
      do_reset(1'b0);
      step();
      step();
      step();
      expect_head("t2.full", 8'h00);
      check("t2.full.addr", 32'(bus.rom_addr_o), 32'd2);
      bus.inst_ready_i = 1'b1;
      for (int i = 1; i < 4; i++) begin
         step();
         expect_head($sformatf("t2.d%0d", i), A'(i));
      end

      // 3: redirect while full flushes and resumes at the target two cycles later.
      do_reset(1'b0);
      step();
      step();
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 8'h40;
      step();
      bus.redirect_i    = 1'b0;
      expect_empty("t3.flush", 8'h40);
      step();
      expect_head("t3.tgt", 8'h40);

      // 4: head pc=5 handshaken in the redirect cycle is consumed once.
      do_reset(1'b1);
      for (int i = 0; i < 6; i++) step();
      expect_head("t4.head5", 8'h05);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 8'h80;
      step();
      bus.redirect_i    = 1'b0;
      expect_empty("t4.flush", 8'h80);
      step();
      expect_head("t4.tgt0", 8'h80);
      step();
      expect_head("t4.tgt1", 8'h81);

      // 6: halt drains the queue with the PC frozen; redirect still works under halt.
      do_reset(1'b0);
      step();
      step();
      bus.halt_i       = 1'b1;
      bus.inst_ready_i = 1'b1;
      expect_head("t6.q0", 8'h00);
      step();
      expect_head("t6.q1", 8'h01);
      check("t6.q1.addr", 32'(bus.rom_addr_o), 32'd2);
      step();
      expect_empty("t6.drained", 8'h02);
      step();
      expect_empty("t6.frozen", 8'h02);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 8'h20;
      step();
      bus.redirect_i    = 1'b0;
      expect_empty("t6.hredir", 8'h20);
      step();
      expect_empty("t6.hhold", 8'h20);
      bus.halt_i = 1'b0;
      step();
      expect_head("t6.res0", 8'h20);
      step();
      expect_head("t6.res1", 8'h21);
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_empty("t6.midrst", 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
